mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Shares one combinational 16x16→32 multiply unit between two requesters: execute slot 0 and execute slot 1 (for example the MUL path and an address-scaling helper).
- Round-robin arbitration, valid/ready handshakes on both request and response sides, and a registered operand/result path.
- Sits between the execute stage and the multiply_unit instance. It drives that unit's operand_a, operand_b and is_signed inputs and samples its result_lo and result_hi outputs.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  arbiter accepts requester 0 this cycle
- req0_a  in  16  operand A
- req0_b  in  16  operand B
- req0_signed  in  1  1 = SMULL, 0 = UMULL
- req0_tag  in  TAG_W  returned unchanged with the result
- req1_valid, req1_ready, req1_a, req1_b, req1_signed, req1_tag  same as requester 0
- mul_operand_a  out  16  to multiply unit operand_a
- mul_operand_b  out  16  to multiply unit operand_b
- mul_is_signed  out  1  to multiply unit is_signed
- mul_result_lo  in  16  from multiply unit result_lo
- mul_result_hi  in  16  from multiply unit result_hi
- rsp0_valid  out  1  result for requester 0 is valid
- rsp0_ready  in  1  requester 0 consumes the result
- rsp0_lo  out  16  product[15:0]
- rsp0_hi  out  16  product[31:16]
- rsp0_tag  out  TAG_W  tag of that operation
- rsp1_valid, rsp1_ready, rsp1_lo, rsp1_hi, rsp1_tag  same as requester 0
- busy  out  1  state != IDLE
- op_count  out  16  completed-response counter

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, last_grant=1 (so requester 0 wins first), grant_id=0.
  - All operand/result/tag registers = 0.
  - rsp0_valid=rsp1_valid=0, op_count=0, busy=0.
  - Any in-flight operation is discarded; no response is ever produced for it.
- FSM states:
  - IDLE: reqN_ready is combinational.
    - Only one valid: that requester is granted.
    - Both valid: grant !last_grant.
    - Neither valid: both readies = 0, stay IDLE.
    - On grant: latch a, b, signed, tag and grant_id; last_grant←grant_id; go EXEC.
    - At most one ready is high in any cycle. Both readies are 0 outside IDLE.
  - EXEC: mul_* outputs are driven from the operand registers, as always.
    - At the end of the cycle, capture mul_result_lo/hi and the tag into the response registers of grant_id.
    - Set rsp[grant_id]_valid=1; go RESP.
  - RESP: hold the response stable while rsp[grant_id]_valid=1 and ready=0.
    - On valid&ready: clear valid, op_count+1, go IDLE.
- Latency and throughput:
  - Handshake accepted at cycle T; rsp valid from cycle T+2.
  - Back-to-back operations (ready asserted immediately) start every 3 cycles.
- Data path:
  - mul_operand_a, mul_operand_b and mul_is_signed are always the registered operands, never request inputs passed straight through.
  - They hold their values after completion until the next grant.
- Response outputs:
  - rspN_lo, rspN_hi and rspN_tag hold their last captured value when valid=0.
  - Only the granted requester's response registers update.
- Other outputs:
  - op_count is 16-bit and wraps 0xFFFF→0x0000.
  - busy is high in EXEC and RESP.
- Fairness: once requester 0 is granted, a continuously valid requester 1 is granted next if it is valid in the next IDLE. Starvation-free for both.
- Request-side obligations:
  - A requester whose valid drops before ready is simply not granted.
  - Request fields need only be stable in the handshake cycle.

Test Plan:
- Unsigned: reset, req0 valid a=0xFFFF b=0xFFFF signed=0 tag=3 → req0_ready at T; rsp0_valid at T+2 with lo=0x0001, hi=0xFFFE, tag=3; op_count=1 after rsp0_ready.
- Signed: req1 a=0xFFFF b=0x0002 signed=1 → rsp1 lo=0xFFFE hi=0xFFFF. Second op a=0x8000 b=0x8000 signed=1 → lo=0x0000 hi=0x4000. Same operands with signed=0 → hi=0x4000 lo=0x0000.
- Contention: both valid continuously from reset, rsp ready tied 1 → grant order 0,1,0,1, each start 3 cycles apart. rsp1 never asserts while rsp0 is valid.
- Backpressure: rsp0_ready held 0 for 5 cycles → rsp0_valid, lo, hi and tag stable; busy=1; req1_ready=0 throughout. Release ready → IDLE next cycle, req1 granted.
- Reset mid-op: assert rst during EXEC → next cycle all rsp_valid=0, busy=0, op_count=0; the aborted operation never responds; next grant goes to requester 0.
- Counter wrap: force 65536 completions, or 65535 then one more → op_count returns to 0x0000.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one external 16x16 multiply unit between two
// execute-slot requesters, with registered operands and per-requester responses.
module mul_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req0_signed,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic             req1_signed,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [15:0]      mul_operand_a,
  output logic [15:0]      mul_operand_b,
  output logic             mul_is_signed,
  input  logic [15:0]      mul_result_lo,
  input  logic [15:0]      mul_result_hi,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [15:0]      rsp0_lo,
  output logic [15:0]      rsp0_hi,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [15:0]      rsp1_lo,
  output logic [15:0]      rsp1_hi,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_id;
  logic             grant_vld;
  logic             grant_sel;
  logic             rsp_hs;

  logic [15:0]      op_a_p0;
  logic [15:0]      op_b_p0;
  logic             op_signed_p0;
  logic [TAG_W-1:0] op_tag_p0;

  logic [15:0]      rsp0_lo_p1, rsp0_hi_p1, rsp1_lo_p1, rsp1_hi_p1;
  logic [TAG_W-1:0] rsp0_tag_p1, rsp1_tag_p1;
  logic             vld0_p1, vld1_p1;

  always_comb begin
    state_nxt  = state;
    grant_vld  = 1'b0;
    grant_sel  = 1'b0;
    rsp_hs     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        // Contention goes to whoever did not win last time.
        if (req0_valid && req1_valid) begin
          grant_vld = 1'b1;
          grant_sel = ~last_grant;
        end else if (req0_valid) begin
          grant_vld = 1'b1;
          grant_sel = 1'b0;
        end else if (req1_valid) begin
          grant_vld = 1'b1;
          grant_sel = 1'b1;
        end
        req0_ready = grant_vld && !grant_sel;
        req1_ready = grant_vld && grant_sel;
        if (grant_vld) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_hs = grant_id ? (vld1_p1 && rsp1_ready) : (vld0_p1 && rsp0_ready);
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      op_a_p0      <= '0;
      op_b_p0      <= '0;
      op_signed_p0 <= 1'b0;
      op_tag_p0    <= '0;
      rsp0_lo_p1   <= '0;
      rsp0_hi_p1   <= '0;
      rsp0_tag_p1  <= '0;
      rsp1_lo_p1   <= '0;
      rsp1_hi_p1   <= '0;
      rsp1_tag_p1  <= '0;
      vld0_p1      <= 1'b0;
      vld1_p1      <= 1'b0;
      op_count     <= '0;
    end else begin
      state <= state_nxt;
      // p0: operand capture at grant; held until the next grant.
      if (grant_vld) begin
        grant_id     <= grant_sel;
        last_grant   <= grant_sel;
        op_a_p0      <= grant_sel ? req1_a      : req0_a;
        op_b_p0      <= grant_sel ? req1_b      : req0_b;
        op_signed_p0 <= grant_sel ? req1_signed : req0_signed;
        op_tag_p0    <= grant_sel ? req1_tag    : req0_tag;
      end
      // p1: product capture into the granted requester's response slot.
      if (state == EXEC) begin
        if (grant_id) begin
          rsp1_lo_p1  <= mul_result_lo;
          rsp1_hi_p1  <= mul_result_hi;
          rsp1_tag_p1 <= op_tag_p0;
          vld1_p1     <= 1'b1;
        end else begin
          rsp0_lo_p1  <= mul_result_lo;
          rsp0_hi_p1  <= mul_result_hi;
          rsp0_tag_p1 <= op_tag_p0;
          vld0_p1     <= 1'b1;
        end
      end
      if (rsp_hs) begin
        if (grant_id) vld1_p1 <= 1'b0;
        else          vld0_p1 <= 1'b0;
        op_count <= op_count + 16'd1;
      end
    end
  end

  assign mul_operand_a = op_a_p0;
  assign mul_operand_b = op_b_p0;
  assign mul_is_signed = op_signed_p0;

  assign rsp0_valid = vld0_p1;
  assign rsp0_lo    = rsp0_lo_p1;
  assign rsp0_hi    = rsp0_hi_p1;
  assign rsp0_tag   = rsp0_tag_p1;
  assign rsp1_valid = vld1_p1;
  assign rsp1_lo    = rsp1_lo_p1;
  assign rsp1_hi    = rsp1_hi_p1;
  assign rsp1_tag   = rsp1_tag_p1;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: models the external multiply unit and keeps
// per-requester scoreboards filled at request handshakes, drained at responses.
module tb_mul_arbiter;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             r0v, r1v, r0_s, r1_s;
  logic [15:0]      r0_a, r0_b, r1_a, r1_b;
  logic [TAG_W-1:0] r0_tag, r1_tag;
  logic             req0_ready, req1_ready;
  logic [15:0]      mul_operand_a, mul_operand_b, mul_result_lo, mul_result_hi;
  logic             mul_is_signed;
  logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [15:0]      rsp0_lo, rsp0_hi, rsp1_lo, rsp1_hi;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
  logic             busy;
  logic [15:0]      op_count;

  int total = 0;
  int bad   = 0;
  logic [35:0] q0[$];
  logic [35:0] q1[$];

  function automatic logic [31:0] mul_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
    logic signed [31:0] sa, sb;
    logic [31:0] ua, ub;
    if (s) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return sa * sb;
    end
    ua = {16'h0, a};
    ub = {16'h0, b};
    return ua * ub;
  endfunction

  assign {mul_result_hi, mul_result_lo} = mul_model(mul_operand_a, mul_operand_b, mul_is_signed);

  mul_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(req0_ready), .req0_a(r0_a), .req0_b(r0_b),
    .req0_signed(r0_s), .req0_tag(r0_tag),
    .req1_valid(r1v), .req1_ready(req1_ready), .req1_a(r1_a), .req1_b(r1_b),
    .req1_signed(r1_s), .req1_tag(r1_tag),
    .mul_operand_a(mul_operand_a), .mul_operand_b(mul_operand_b),
    .mul_is_signed(mul_is_signed),
    .mul_result_lo(mul_result_lo), .mul_result_hi(mul_result_hi),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_lo(rsp0_lo),
    .rsp0_hi(rsp0_hi), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_lo(rsp1_lo),
    .rsp1_hi(rsp1_hi), .rsp1_tag(rsp1_tag),
    .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // Runs once per cycle, well after the edge: handshakes push, responses pop.
  task automatic observe();
    if (!rst) begin
      chk("one_ready", {63'h0, req0_ready & req1_ready}, 64'h0);
      chk("rsp_excl", {63'h0, rsp0_valid & rsp1_valid}, 64'h0);
      if (r0v && req0_ready) q0.push_back({r0_tag, mul_model(r0_a, r0_b, r0_s)});
      if (r1v && req1_ready) q1.push_back({r1_tag, mul_model(r1_a, r1_b, r1_s)});
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 64'h1, 64'h0);
        else chk("rsp0_data", {28'h0, rsp0_tag, rsp0_hi, rsp0_lo}, {28'h0, q0.pop_front()});
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 64'h1, 64'h0);
        else chk("rsp1_data", {28'h0, rsp1_tag, rsp1_hi, rsp1_lo}, {28'h0, q1.pop_front()});
      end
    end
  endtask

  task automatic tick();
    #1;
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input bit id, input string tag);
    int n = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {63'h0, id ? req1_ready : req0_ready}, 64'h1);
  endtask

  task automatic wait_rsp(input bit id, input string tag);
    int n = 0;
    #1;
    while (!(id ? rsp1_valid : rsp0_valid) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {63'h0, id ? rsp1_valid : rsp0_valid}, 64'h1);
  endtask

  task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [TAG_W-1:0] tg);
    if (id) begin r1v = 1'b1; r1_a = a; r1_b = b; r1_s = s; r1_tag = tg; end
    else    begin r0v = 1'b1; r0_a = a; r0_b = b; r0_s = s; r0_tag = tg; end
    wait_req(id, "op_ready_timeout");
    tick();
    r0v = 1'b0;
    r1v = 1'b0;
    if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    wait_rsp(id, "op_rsp_timeout");
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    r0v = 1'b0; r1v = 1'b0; r0_s = 1'b0; r1_s = 1'b0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0; r0_tag = '0; r1_tag = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    do_reset();

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);
    chk("rst_v0", rsp0_valid, 0);
    chk("rst_v1", rsp1_valid, 0);
    chk("rst_opa", mul_operand_a, 0);
    chk("rst_opb", mul_operand_b, 0);
    chk("rst_lo0", rsp0_lo, 0);
    chk("rst_rdy0", req0_ready, 0);

    // Unsigned FFFF*FFFF with exact cycle timing
    r0v = 1'b1; r0_a = 16'hFFFF; r0_b = 16'hFFFF; r0_s = 1'b0; r0_tag = 4'd3;
    #1;
    chk("u_rdy0_T", req0_ready, 1);
    chk("u_rdy1_T", req1_ready, 0);
    tick();
    r0v = 1'b0;
    #1;
    chk("u_busy_T1", busy, 1);
    chk("u_v0_T1", rsp0_valid, 0);
    chk("u_opa_T1", mul_operand_a, 16'hFFFF);
    chk("u_sgn_T1", mul_is_signed, 0);
    tick();
    #1;
    chk("u_v0_T2", rsp0_valid, 1);
    chk("u_lo", rsp0_lo, 16'h0001);
    chk("u_hi", rsp0_hi, 16'hFFFE);
    chk("u_tag", rsp0_tag, 3);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    #1;
    chk("u_count", op_count, 1);
    chk("u_busy_done", busy, 0);
    chk("u_hold_lo", rsp0_lo, 16'h0001);
    chk("u_opa_hold", mul_operand_a, 16'hFFFF);

    // Signed and unsigned corner products
    run_op(1'b1, 16'hFFFF, 16'h0002, 1'b1, 4'd6);
    chk("s1_lo", rsp1_lo, 16'hFFFE);
    chk("s1_hi", rsp1_hi, 16'hFFFF);
    chk("s1_tag", rsp1_tag, 6);
    run_op(1'b1, 16'h8000, 16'h8000, 1'b1, 4'd1);
    chk("s2_lo", rsp1_lo, 16'h0000);
    chk("s2_hi", rsp1_hi, 16'h4000);
    run_op(1'b0, 16'h8000, 16'h8000, 1'b0, 4'd2);
    chk("s3_lo", rsp0_lo, 16'h0000);
    chk("s3_hi", rsp0_hi, 16'h4000);
    chk("s3_lo1_untouched", rsp1_hi, 16'h4000);
    chk("s_count", op_count, 4);

    // Contention from reset: grants alternate 0,1,0,1 every 3 cycles
    do_reset();
    r0v = 1'b1; r1v = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      r0_a = 16'($urandom); r0_b = 16'($urandom); r0_s = 1'($urandom); r0_tag = 4'($urandom);
      r1_a = 16'($urandom); r1_b = 16'($urandom); r1_s = 1'($urandom); r1_tag = 4'($urandom);
      #1;
      chk($sformatf("cont_rdy0_k%0d", k), req0_ready, (k % 3 == 0) && ((k / 3) % 2 == 0));
      chk($sformatf("cont_rdy1_k%0d", k), req1_ready, (k % 3 == 0) && ((k / 3) % 2 == 1));
      tick();
    end
    r0v = 1'b0; r1v = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    #1;
    chk("cont_count", op_count, 4);
    chk("cont_q0_empty", q0.size(), 0);
    chk("cont_q1_empty", q1.size(), 0);

    // Backpressure on rsp0 with requester 1 waiting
    r0v = 1'b1; r0_a = 16'h1234; r0_b = 16'h5678; r0_s = 1'b0; r0_tag = 4'd5;
    #1;
    chk("bp_rdy0", req0_ready, 1);
    tick();
    r0v = 1'b0;
    r1v = 1'b1; r1_a = 16'h0003; r1_b = 16'h0007; r1_s = 1'b0; r1_tag = 4'd9;
    #1;
    chk("bp_exec_rdy1", req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_v0", rsp0_valid, 1);
      chk("bp_data", {rsp0_tag, rsp0_hi, rsp0_lo}, {4'd5, 16'h0626, 16'h0060});
      chk("bp_busy", busy, 1);
      chk("bp_rdy1", req1_ready, 0);
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    #1;
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_rdy1", req1_ready, 1);
    chk("bp_idle_v0", rsp0_valid, 0);
    tick();
    r1v = 1'b0;
    rsp1_ready = 1'b1;
    wait_rsp(1'b1, "bp_rsp1_timeout");
    chk("bp_r1_lo", rsp1_lo, 16'h0015);
    tick();
    rsp1_ready = 1'b0;
    chk("bp_count", op_count, 6);

    // Reset during EXEC: operation is dropped, requester 0 wins next
    r0v = 1'b1; r0_a = 16'h0011; r0_b = 16'h0011; r0_s = 1'b0; r0_tag = 4'd7;
    wait_req(1'b0, "rm_ready_timeout");
    tick();
    r0v = 1'b0;
    #1;
    chk("rm_exec_busy", busy, 1);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    tick();
    rst = 1'b0;
    #1;
    chk("rm_v0", rsp0_valid, 0);
    chk("rm_v1", rsp1_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_count", op_count, 0);
    rsp0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rm_no_rsp", rsp0_valid, 0);
      tick();
    end
    rsp0_ready = 1'b0;
    r0v = 1'b1; r1v = 1'b1;
    r0_a = 16'h0100; r0_b = 16'h0100; r0_s = 1'b1; r0_tag = 4'd4;
    r1_a = 16'h0002; r1_b = 16'h0002; r1_s = 1'b0; r1_tag = 4'd8;
    #1;
    chk("rm_rdy0", req0_ready, 1);
    chk("rm_rdy1", req1_ready, 0);
    tick();
    r0v = 1'b0; r1v = 1'b0;
    rsp0_ready = 1'b1;
    wait_rsp(1'b0, "rm_rsp0_timeout");
    chk("rm_hi", rsp0_hi, 16'h0001);
    tick();
    rsp0_ready = 1'b0;
    chk("rm_count_after", op_count, 1);

    // Counter wrap: preload the counter just below rollover
    force dut.op_count = 16'hFFFF;
    tick();
    release dut.op_count;
    run_op(1'b1, 16'h0005, 16'h0005, 1'b0, 4'd2);
    chk("wrap_zero", op_count, 16'h0000);
    run_op(1'b0, 16'hFFFE, 16'h0003, 1'b1, 4'd11);
    chk("wrap_one", op_count, 16'h0001);
    chk("wrap_lo", rsp0_lo, 16'hFFFA);
    chk("wrap_hi", rsp0_hi, 16'hFFFF);

    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
